// File: rtl/coincident_trigger_gen_if.sv
// Control/config and trigger bundle for coincident_trigger_gen.
// COINCIDENT_TRIG_COUNT_EN adds the coinc_count observation port.
interface coincident_trigger_gen_if #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8,
  parameter int BURST_W  = 16
);
  logic                start;
  logic                stop;
  logic [CNT_W-1:0]    half_period;
  logic [CNT_W-1:0]    skew;
  logic [1:0]          mode;
  logic [BURST_W-1:0]  burst_len;
  logic [CHANNELS-1:0] trig;
  logic                coinc;
  logic                busy;
  logic                done;
`ifdef COINCIDENT_TRIG_COUNT_EN
  logic [15:0]         coinc_count;

  modport master (
    output start, stop, half_period, skew, mode, burst_len,
    input  trig, coinc, busy, done, coinc_count
  );
  modport slave (
    input  start, stop, half_period, skew, mode, burst_len,
    output trig, coinc, busy, done, coinc_count
  );
`else
  modport master (
    output start, stop, half_period, skew, mode, burst_len,
    input  trig, coinc, busy, done
  );
  modport slave (
    input  start, stop, half_period, skew, mode, burst_len,
    output trig, coinc, busy, done
  );
`endif
endinterface

// File: rtl/coincident_trigger_gen.sv
// Multi-channel square-wave trigger generator with per-channel skew and burst control.
// Optional COINCIDENT_TRIG_COUNT_EN: saturating 16-bit count of coinc cycles per run.
module coincident_trigger_gen #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8,
  parameter int BURST_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  coincident_trigger_gen_if.slave   bus
);
  localparam int D_W  = CNT_W + $clog2(CHANNELS);
  localparam int PH_W = BURST_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [D_W-1:0]   D_ONE   = D_W'(1'b1);
  localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1'b1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    hp_r;
  logic [BURST_W-1:0]  bl_r;
  logic [D_W-1:0]      dly_r [CHANNELS];
  logic [CNT_W-1:0]    hp_cnt_r [CHANNELS];
  logic [PH_W-1:0]     phase_r [CHANNELS];
  logic [CHANNELS-1:0] trig_r;
  logic                coinc_r;
  logic                busy_r;
  logic                done_r;

  logic [D_W-1:0]      dly_init_s [CHANNELS];
  logic [D_W-1:0]      dly_nxt_s [CHANNELS];
  logic [CNT_W-1:0]    hp_cnt_nxt_s [CHANNELS];
  logic [PH_W-1:0]     phase_nxt_s [CHANNELS];
  logic [PH_W-1:0]     bl2_s;
  logic [CHANNELS-1:0] trig_nxt_s;
  logic [CHANNELS-1:0] trig_out_s;
  logic                all_done_s;
  logic                start_acc_s;

  function automatic logic multi_toggle(input logic [CHANNELS-1:0] diff);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (diff[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    return multi;
  endfunction

  assign bl2_s       = {bl_r, 1'b0};
  assign start_acc_s = (state_r == IDLE) && bus.start && !bus.stop;

  // Per-channel start delay from the live skew/mode, captured on start.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      case (bus.mode)
        2'd1:    dly_init_s[i] = D_W'(i) * D_W'(bus.skew);
        2'd2:    dly_init_s[i] = D_W'(CHANNELS - 1 - i) * D_W'(bus.skew);
        default: dly_init_s[i] = {D_W{1'b0}};
      endcase
    end
  end

  // Channel counters: phase counts completed half-periods; odd phase means high.
  always_comb begin
    trig_nxt_s = {CHANNELS{1'b0}};
    all_done_s = (bl_r != {BURST_W{1'b0}});
    for (int i = 0; i < CHANNELS; i++) begin
      dly_nxt_s[i]    = dly_r[i];
      hp_cnt_nxt_s[i] = hp_cnt_r[i];
      phase_nxt_s[i]  = phase_r[i];
      if (dly_r[i] != {D_W{1'b0}}) begin
        dly_nxt_s[i] = dly_r[i] - D_ONE;
      end else if ((bl_r != {BURST_W{1'b0}}) && (phase_r[i] == bl2_s)) begin
        phase_nxt_s[i] = phase_r[i];
      end else if (hp_cnt_r[i] == hp_r - CNT_ONE) begin
        hp_cnt_nxt_s[i] = {CNT_W{1'b0}};
        phase_nxt_s[i]  = phase_r[i] + PH_ONE;
      end else begin
        hp_cnt_nxt_s[i] = hp_cnt_r[i] + CNT_ONE;
      end
      trig_nxt_s[i] = phase_nxt_s[i][0] &&
                      ((bl_r == {BURST_W{1'b0}}) || (phase_nxt_s[i] < bl2_s));
      all_done_s    = all_done_s && (phase_nxt_s[i] == bl2_s);
    end
  end

  // Trigger level presented after the next edge.
  always_comb begin
    trig_out_s = {CHANNELS{1'b0}};
    if ((state_r == RUN) && !bus.stop && !all_done_s) begin
      trig_out_s = trig_nxt_s;
    end else begin
      trig_out_s = {CHANNELS{1'b0}};
    end
  end

  // Run-control FSM with registered outputs and channel counter updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      hp_r    <= {CNT_W{1'b0}};
      bl_r    <= {BURST_W{1'b0}};
      trig_r  <= {CHANNELS{1'b0}};
      coinc_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        dly_r[i]    <= {D_W{1'b0}};
        hp_cnt_r[i] <= {CNT_W{1'b0}};
        phase_r[i]  <= {PH_W{1'b0}};
      end
    end else begin
      trig_r  <= trig_out_s;
      coinc_r <= multi_toggle(trig_out_s ^ trig_r);
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start_acc_s) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            hp_r    <= (bus.half_period == {CNT_W{1'b0}}) ? CNT_ONE : bus.half_period;
            bl_r    <= bus.burst_len;
            for (int i = 0; i < CHANNELS; i++) begin
              dly_r[i]    <= dly_init_s[i];
              hp_cnt_r[i] <= {CNT_W{1'b0}};
              phase_r[i]  <= {PH_W{1'b0}};
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (all_done_s) begin
            state_r <= FINISH;
            done_r  <= 1'b1;
          end else begin
            for (int i = 0; i < CHANNELS; i++) begin
              dly_r[i]    <= dly_nxt_s[i];
              hp_cnt_r[i] <= hp_cnt_nxt_s[i];
              phase_r[i]  <= phase_nxt_s[i];
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trig  = trig_r;
  assign bus.coinc = coinc_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

`ifdef COINCIDENT_TRIG_COUNT_EN
  logic [15:0] coinc_count_r;

  // Saturating tally of coincident cycles while a run is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coinc_count_r <= 16'h0000;
    end else if (start_acc_s) begin
      coinc_count_r <= 16'h0000;
    end else if ((state_r != IDLE) && coinc_r && (coinc_count_r != 16'hFFFF)) begin
      coinc_count_r <= coinc_count_r + 16'h0001;
    end else begin
      coinc_count_r <= coinc_count_r;
    end
  end

  assign bus.coinc_count = coinc_count_r;
`endif
endmodule

// File: tb/tb_coincident_trigger_gen.sv
// Randomized self-checking bench for coincident_trigger_gen against a waveform-formula model.
module tb_coincident_trigger_gen;
  localparam int CH = 4;
  localparam int CW = 8;
  localparam int BW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  coincident_trigger_gen_if #(.CHANNELS(CH), .CNT_W(CW), .BURST_W(BW)) bus ();

  coincident_trigger_gen #(.CHANNELS(CH), .CNT_W(CW), .BURST_W(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Channel i is high when r lies in [d+(2k+1)hp, d+(2k+2)hp) for some k < bl.
  function automatic logic [CH-1:0] model_trig(int r, int hp, int skew, int mode, int bl);
    logic [CH-1:0] v;
    int d;
    int p;
    v = '0;
    for (int i = 0; i < CH; i++) begin
      d = (mode == 1) ? i * skew : (mode == 2) ? (CH - 1 - i) * skew : 0;
      if (r >= d) begin
        p = (r - d) / hp;
        v[i] = (p % 2 == 1) && (bl == 0 || p < 2 * bl);
      end
    end
    return v;
  endfunction

  function automatic logic multi(input logic [CH-1:0] x);
    return $countones(x) >= 2;
  endfunction

  task automatic run_case(input int hp, input int skew, input int mode, input int bl,
                          input int stop_at, input int restart_at, input int rst_at);
    int hpe;
    int maxd;
    int r_end;
    int last;
    int cc;
    logic [CH-1:0] prev;
    logic [CH-1:0] cur;
    hpe   = (hp == 0) ? 1 : hp;
    maxd  = (mode == 1 || mode == 2) ? (CH - 1) * skew : 0;
    r_end = (bl == 0) ? 32'h3fff_ffff : maxd + 2 * hpe * bl;
    last  = (stop_at >= 0 && stop_at < r_end) ? stop_at : r_end;
    @(negedge clk);
    bus.half_period = hp[CW-1:0];
    bus.skew        = skew[CW-1:0];
    bus.mode        = mode[1:0];
    bus.burst_len   = bl[BW-1:0];
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start       = 1'b0;
    bus.half_period = CW'($urandom);
    bus.skew        = CW'($urandom);
    bus.mode        = 2'($urandom);
    bus.burst_len   = BW'($urandom);
    prev = '0;
    cc   = 0;
    for (int r = 0; r <= last + 3; r++) begin
      if (r == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_trig", 32'(bus.trig), 32'd0);
        check_val("rst_coinc", 32'(bus.coinc), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      cur = (r <= last) ? model_trig(r, hpe, skew, mode, bl) : '0;
      check_val($sformatf("trig r=%0d", r), 32'(bus.trig), 32'(cur));
      check_val($sformatf("coinc r=%0d", r), 32'(bus.coinc), 32'(multi(cur ^ prev)));
      check_val($sformatf("busy r=%0d", r), 32'(bus.busy), 32'(r <= last));
      check_val($sformatf("done r=%0d", r), 32'(bus.done),
                32'(bl != 0 && r == r_end && last == r_end));
      if (r <= last && multi(cur ^ prev)) cc++;
      prev = cur;
      bus.stop  = (r == stop_at);
      bus.start = (r == restart_at) && (r < last);
      @(negedge clk);
    end
    bus.stop  = 1'b0;
    bus.start = 1'b0;
`ifdef COINCIDENT_TRIG_COUNT_EN
    check_val("coinc_count", 32'(bus.coinc_count), 32'(cc));
`endif
  endtask

  initial begin
    int hp;
    int sk;
    int md;
    int bl;
    int sa;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.half_period = '0;
    bus.skew        = '0;
    bus.mode        = '0;
    bus.burst_len   = '0;
    repeat (2) @(negedge clk);
    check_val("reset_trig", 32'(bus.trig), 32'd0);
    check_val("reset_busy", 32'(bus.busy), 32'd0);
    check_val("reset_done", 32'(bus.done), 32'd0);
    check_val("reset_coinc", 32'(bus.coinc), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    // start and stop together: stop wins
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    bus.half_period = 8'd3;
    bus.burst_len   = 16'd1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_val("start_stop_busy", 32'(bus.busy), 32'd0);

    run_case(10, 0, 0, 3, -1, -1, -1);
    run_case(4, 1, 1, 1, -1, -1, -1);
    run_case(4, 0, 2, 2, -1, -1, -1);
    run_case(0, 3, 0, 2, -1, -1, -1);
    run_case(10, 0, 0, 0, 25, 15, -1);
    run_case(10, 0, 0, 3, -1, -1, 13);
    run_case(10, 0, 0, 3, -1, -1, -1);
    run_case(3, 2, 2, 2, -1, 4, -1);
    run_case(5, 1, 3, 1, -1, -1, -1);

    for (int n = 0; n < 24; n++) begin
      hp = $urandom_range(0, 6);
      sk = $urandom_range(0, 5);
      md = $urandom_range(0, 3);
      bl = $urandom_range(0, 3);
      if (bl == 0) sa = $urandom_range(3, 40);
      else sa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : -1;
      run_case(hp, sk, md, bl, sa, $urandom_range(1, 12), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
